// File: rtl/vga_frame_grabber_if.sv
// Avalon-MM slave bus bundle for the VGA frame grabber register window.
interface vga_frame_grabber_if;
    logic [7:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        write;
    logic        read;
    logic        chipselect;

    modport master (
        output address, writedata, write, read, chipselect,
        input  readdata
    );

    modport slave (
        input  address, writedata, write, read, chipselect,
        output readdata
    );
endinterface

// File: rtl/vga_frame_grabber.sv
// Captures one decimated VGA frame into a show-ahead FIFO on software ARM;
// software drains it through Avalon register reads.
module vga_frame_grabber #(
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned CW         = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_frame_grabber_if.slave   bus,
    input  logic                 pix_ce,
    input  logic [7:0]           VGA_R,
    input  logic [7:0]           VGA_G,
    input  logic [7:0]           VGA_B,
    input  logic                 HSYNC,
    input  logic                 VSYNC,
    input  logic                 VGA_BLANK_n,
    output logic                 busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   x_q, x_d;
    logic [CW-1:0]   y_q, y_d;
    logic            line_act_q, line_act_d;
    logic            ovf_q, ovf_d;
    logic            hs_q, vs_q;
    logic            busy_q, busy_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    pixel_t          mem_q [FIFO_DEPTH];

    logic   wr_en, arm_req, abort_req, data_rd;
    logic   vs_fall, hs_fall, active, keep;
    logic   empty, full, flush, push_req, push_ok, pop_ok;
    pixel_t pix;
    logic   unused_wdata;

    assign wr_en        = bus.chipselect & bus.write & (bus.address == 8'd0);
    assign arm_req      = wr_en & bus.writedata[0];
    assign abort_req    = wr_en & bus.writedata[1];
    assign data_rd      = bus.chipselect & bus.read & (bus.address == 8'd0);
    assign unused_wdata = ^bus.writedata[31:2];

    assign vs_fall = vs_q & ~VSYNC;
    assign hs_fall = hs_q & ~HSYNC;
    assign active  = pix_ce & VGA_BLANK_n;
    assign keep    = ((x_q % CW'(DECIM)) == '0) && ((y_q % CW'(DECIM)) == '0);
    assign pix     = '{r: VGA_R, g: VGA_G, b: VGA_B};

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign push_ok = push_req & ~full;
    assign pop_ok  = data_rd & ~empty & ~flush;

    // Capture FSM and raster counters; ABORT overrides everything
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        line_act_d = line_act_q;
        flush      = 1'b0;
        push_req   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm_req) begin
                    state_d = ST_ARMED;
                    flush   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (vs_fall) begin
                    state_d    = ST_CAPTURE;
                    x_d        = '0;
                    y_d        = '0;
                    line_act_d = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (active) begin
                    push_req   = keep;
                    x_d        = (x_q == '1) ? x_q : x_q + CW'(1);
                    line_act_d = 1'b1;
                end
                if (hs_fall) begin
                    x_d = '0;
                    if (line_act_d) begin
                        y_d        = (y_q == '1) ? y_q : y_q + CW'(1);
                        line_act_d = 1'b0;
                    end
                end
                if (vs_fall) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_req) begin
            state_d  = ST_IDLE;
            flush    = 1'b1;
            push_req = 1'b0;
        end
    end

    // FIFO pointers, level and sticky overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push_req && full) begin
                ovf_d = 1'b1;
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            line_act_q <= 1'b0;
            ovf_q      <= 1'b0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            line_act_q <= line_act_d;
            ovf_q      <= ovf_d;
            hs_q       <= HSYNC;
            vs_q       <= VSYNC;
            busy_q     <= busy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Storage array carries no reset; validity is tracked by level_q
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= pix;
        end
    end

    assign busy = busy_q;

    // Register read mux: DATA shows the FIFO head, STATUS packs level/flags/state
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            8'd0: begin
                if (!empty) begin
                    bus.readdata = {1'b1, 7'b0, mem_q[rd_ptr_q]};
                end
            end
            8'd1: bus.readdata = {16'(level_q), 12'b0, empty, ovf_q, state_q};
            default: bus.readdata = '0;
        endcase
    end

endmodule
